uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Command decoder that consumes 128-bit packets from the UART receive path and turns BBB commands into register loads, input-vector SRAM writes, an execute trigger and SRAM readback through the UART transmit path. It sits between the UART controller and the vector-execution engine. It is the only block that drives the receive retrieve strobe and the transmit capture/transmit/ack strobes.

## Interface
- DEPTH_BITS, 8, address width of the input-vector SRAM; capacity is 2^DEPTH_BITS vectors.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- RXDATA_READY  in  1  a received packet is waiting.
- RXDATA  in  128  received packet.
- RXDATA_RETRIEVED  out  1  one-cycle pulse; packet consumed.
- TEMPLATE, FORCE_FMT, CYCLE  out  128 each  held vector registers.
- DELAY1, DELAY2, WIDTH, LENGTH  out  8 each  timing registers.
- VEC_WE  out  1  one-cycle SRAM write strobe.
- VEC_ADDR  out  DEPTH_BITS  SRAM write address.
- VEC_WDATA  out  128  SRAM write data.
- VEC_COUNT  out  DEPTH_BITS+1  number of input vectors loaded.
- EXEC_START  out  1  one-cycle pulse to the execution engine.
- EXEC_DONE  in  1  one-cycle pulse from the engine when execution completes.
- RD_EN  out  1  SRAM read strobe.
- RD_ADDR  out  DEPTH_BITS  readback counter.
- RD_DATA  in  128  SRAM read data, valid 1 cycle after RD_EN.
- TXDATA  out  128  readback word.
- TXCAPTURE, TXTRANSMIT, TXACK  out  1 each  one-cycle transmit strobes.
- TXSENT  in  1  transmit complete, held until TXACK.
- ILLEGAL  out  1  one-cycle pulse on an unknown or rejected command.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- Opcode is RXDATA[7:0] of a command packet; RXDATA[127:8] is ignored.
- Opcodes 0–4 take one payload packet. Opcodes 5–6 have no payload.
- Acceptance rule:
  - A packet is accepted when RXDATA_READY=1 in IDLE or PAYLOAD and the armed flag is set.
  - Acceptance pulses RXDATA_RETRIEVED and samples RXDATA in the same cycle, then clears the armed flag.
  - The armed flag is set whenever RXDATA_READY=0.
- FSM states: IDLE, PAYLOAD, EXEC, RD_REQ, RD_WAIT, TX_CAP, TX_SEND, TX_WAIT.
  - IDLE, opcode 0–4 → PAYLOAD (opcode latched).
  - IDLE, opcode 5 with VEC_COUNT>0 → EXEC, pulsing EXEC_START.
  - IDLE, opcode 5 with VEC_COUNT=0 → ILLEGAL pulse, stay in IDLE.
  - IDLE, opcode 6 → RD_REQ.
  - IDLE, opcode ≥7 → ILLEGAL pulse, stay in IDLE.
  - PAYLOAD, on accept, applies the payload and returns to IDLE:
    - 0 → TEMPLATE; 1 → FORCE_FMT; 2 → CYCLE.
    - 3 → VEC_WE pulse with VEC_WDATA=payload at VEC_ADDR; pointer then +1.
    - 4 → DELAY1=[31:24], DELAY2=[23:16], WIDTH=[15:8], LENGTH=[7:0].
  - EXEC: no packets accepted (receiver back-pressured). On EXEC_DONE, RD_ADDR is cleared, the fresh flag is set, and the FSM returns to IDLE.
  - RD_REQ: RD_EN pulse → RD_WAIT → TX_CAP.
  - TX_CAP: TXDATA=RD_DATA and TXCAPTURE pulse → TX_SEND.
  - TX_SEND: TXTRANSMIT pulse → TX_WAIT.
  - TX_WAIT: on TXSENT, TXACK pulse and RD_ADDR+1 (wraps modulo 2^DEPTH_BITS) → IDLE.
- Write pointer:
  - VEC_ADDR equals the low bits of VEC_COUNT.
  - If the fresh flag is set when an opcode-3 payload arrives, VEC_COUNT is cleared to 0 before the write and the flag is cleared.
  - Full means VEC_COUNT=2^DEPTH_BITS. A further opcode-3 payload is still retrieved, but gives no write and an ILLEGAL pulse.

## Timing
- Reset values (RST low, asynchronous):
  - FSM=IDLE; armed=1; fresh=0.
  - All strobes 0.
  - All registers, TXDATA, VEC_COUNT and RD_ADDR 0.
- Packet accept to register update: 1 cycle. Accept to VEC_WE: same edge as the update.
- Opcode 6 accept to TXCAPTURE: 3 cycles. TXCAPTURE to TXTRANSMIT: 1 cycle. TXSENT to TXACK: 1 cycle.
- Opcode 5 accept to EXEC_START: 1 cycle.
- EXEC_DONE outside EXEC is ignored. RXDATA_READY in non-accepting states is left pending.
- Reset mid-operation aborts any transmit handshake with no TXACK. Loaded data is lost.

## Structure
- Shared package holds:
  - Opcode constants: OP_TEMPLATE=0, OP_FORCE=1, OP_CYCLE=2, OP_INPUT=3, OP_TIMING=4, OP_EXEC=5, OP_READ=6.
  - The FSM state encoding.
  - The timing-field bit positions.
- Single flat module; no sub-module needed.

## Test plan
- Opcode 0 then payload 128'h0123…CDEF → TEMPLATE equals the payload 1 cycle after the second RXDATA_RETRIEVED; other registers unchanged.
- Opcode 4 then payload with [31:0]=32'h0A141E64 → DELAY1=10, DELAY2=20, WIDTH=30, LENGTH=100.
- Three opcode-3 packets → VEC_WE at addresses 0, 1, 2 and VEC_COUNT=3. Opcode 5 → EXEC_START, BUSY=1 until EXEC_DONE.
- After EXEC_DONE, opcode 6 twice → RD_EN at addresses 0 then 1. Each gives a TXCAPTURE/TXTRANSMIT pair, then TXACK after TXSENT. Next opcode 3 writes address 0.
- Opcode 5 with VEC_COUNT=0, opcode 9, and opcode 3 when full (DEPTH_BITS=2, 5th vector) → each gives an ILLEGAL pulse, no EXEC_START, no VEC_WE.
- RXDATA_READY held high across the accept → only one RXDATA_RETRIEVED until READY drops. RST low during TX_WAIT → IDLE with all outputs at reset values.

Source files
------------

// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants for the UART command decoder: opcodes, FSM encoding and
// the bit positions of the fields in a timing payload.
package uart_cmd_decoder_pkg;

  localparam int PKT_W = 128;

  // Command opcodes carried in rxdata[7:0] of a command packet
  localparam logic [7:0] OP_TEMPLATE = 8'd0;
  localparam logic [7:0] OP_FORCE    = 8'd1;
  localparam logic [7:0] OP_CYCLE    = 8'd2;
  localparam logic [7:0] OP_INPUT    = 8'd3;
  localparam logic [7:0] OP_TIMING   = 8'd4;
  localparam logic [7:0] OP_EXEC     = 8'd5;
  localparam logic [7:0] OP_READ     = 8'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_EXEC,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_TX_CAP,
    ST_TX_SEND,
    ST_TX_WAIT
  } state_e;

  // Timing payload layout: {delay1, delay2, width, length} in bits [31:0]
  localparam int DELAY1_LSB = 24;
  localparam int DELAY2_LSB = 16;
  localparam int WIDTH_LSB  = 8;
  localparam int LENGTH_LSB = 0;

  // Opcodes 0..4 are followed by exactly one payload packet
  function automatic logic has_payload(input logic [7:0] op);
    return op <= OP_TIMING;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Bundle of the decoder's receive, register, SRAM, execute and transmit
// signals. master = the decoder, slave = UART / SRAM / engine side.
interface uart_cmd_decoder_if #(
  parameter int DEPTH_BITS = 8
);
  import uart_cmd_decoder_pkg::*;

  // receive path
  logic             rxdata_ready;
  logic [PKT_W-1:0] rxdata;
  logic             rxdata_retrieved;

  // held configuration registers
  logic [PKT_W-1:0] template_vec;
  logic [PKT_W-1:0] force_fmt;
  logic [PKT_W-1:0] cycle;
  logic [7:0]       delay1;
  logic [7:0]       delay2;
  logic [7:0]       width;
  logic [7:0]       length;

  // input-vector SRAM write side
  logic                  vec_we;
  logic [DEPTH_BITS-1:0] vec_addr;
  logic [PKT_W-1:0]      vec_wdata;
  logic [DEPTH_BITS:0]   vec_count;

  // execution engine
  logic exec_start;
  logic exec_done;

  // SRAM readback
  logic                  rd_en;
  logic [DEPTH_BITS-1:0] rd_addr;
  logic [PKT_W-1:0]      rd_data;

  // transmit path
  logic [PKT_W-1:0] txdata;
  logic             txcapture;
  logic             txtransmit;
  logic             txack;
  logic             txsent;

  // status
  logic illegal;
  logic busy;

  modport master (
    input  rxdata_ready, rxdata, exec_done, rd_data, txsent,
    output rxdata_retrieved, template_vec, force_fmt, cycle,
           delay1, delay2, width, length,
           vec_we, vec_addr, vec_wdata, vec_count,
           exec_start, rd_en, rd_addr, txdata,
           txcapture, txtransmit, txack, illegal, busy
  );

  modport slave (
    output rxdata_ready, rxdata, exec_done, rd_data, txsent,
    input  rxdata_retrieved, template_vec, force_fmt, cycle,
           delay1, delay2, width, length,
           vec_we, vec_addr, vec_wdata, vec_count,
           exec_start, rd_en, rd_addr, txdata,
           txcapture, txtransmit, txack, illegal, busy
  );

endinterface

// File: rtl/uart_cmd_decoder.sv
// Turns 128-bit UART packets into register loads, input-vector SRAM writes,
// an execute trigger, and one-word SRAM readback through the transmitter.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int DEPTH_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_cmd_decoder_if.master  bus
);

  localparam logic [DEPTH_BITS:0] FULL_COUNT = {1'b1, {DEPTH_BITS{1'b0}}};

  state_e state, state_d;

  logic                  armed;
  logic                  fresh;
  logic [7:0]            op_q;
  logic [PKT_W-1:0]      template_q, force_q, cycle_q, vec_wdata_q, txdata_q;
  logic [7:0]            delay1_q, delay2_q, width_q, length_q;
  logic [DEPTH_BITS:0]   vec_count_q;
  logic [DEPTH_BITS-1:0] rd_addr_q;

  // registered one-cycle strobes and their next values
  logic exec_start_q, illegal_q, vec_we_q, txack_q;
  logic exec_start_d, illegal_d, vec_we_d, txack_d;

  // Moore strobes straight from the state
  logic rd_en, txcapture, txtransmit;

  logic                accept;
  logic [7:0]          rx_op;
  logic [DEPTH_BITS:0] eff_count;
  logic                vec_full;

  // A packet is consumed once per READY assertion, only where we listen
  assign accept = bus.rxdata_ready && armed &&
                  (state == ST_IDLE || state == ST_PAYLOAD);
  assign rx_op  = bus.rxdata[7:0];

  // After an execute the next input vector restarts the list, so the
  // full test must see the count as it will be after that restart.
  assign eff_count = fresh ? '0 : vec_count_q;
  assign vec_full  = (eff_count == FULL_COUNT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (has_payload(rx_op))                          state_d = ST_PAYLOAD;
          else if (rx_op == OP_EXEC && vec_count_q != '0)  state_d = ST_EXEC;
          else if (rx_op == OP_READ)                       state_d = ST_RD_REQ;
        end
      end
      ST_PAYLOAD: if (accept)        state_d = ST_IDLE;
      ST_EXEC:    if (bus.exec_done) state_d = ST_IDLE;
      ST_RD_REQ:                     state_d = ST_RD_WAIT;
      ST_RD_WAIT:                    state_d = ST_TX_CAP;
      ST_TX_CAP:                     state_d = ST_TX_SEND;
      ST_TX_SEND:                    state_d = ST_TX_WAIT;
      ST_TX_WAIT: if (bus.txsent)    state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Output decode: Moore strobes plus next values of the registered pulses
  always_comb begin
    exec_start_d = 1'b0;
    illegal_d    = 1'b0;
    vec_we_d     = 1'b0;
    txack_d      = 1'b0;
    rd_en        = 1'b0;
    txcapture    = 1'b0;
    txtransmit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (rx_op == OP_EXEC) begin
            if (vec_count_q != '0) exec_start_d = 1'b1;
            else                   illegal_d    = 1'b1;
          end else if (rx_op > OP_READ) begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept && op_q == OP_INPUT) begin
          if (vec_full) illegal_d = 1'b1;
          else          vec_we_d  = 1'b1;
        end
      end
      ST_RD_REQ:  rd_en      = 1'b1;
      ST_TX_CAP:  txcapture  = 1'b1;
      ST_TX_SEND: txtransmit = 1'b1;
      ST_TX_WAIT: if (bus.txsent) txack_d = 1'b1;
      default: ;
    endcase
  end

  // Pulse outputs are registered so they land one cycle after the cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_start_q <= 1'b0;
      illegal_q    <= 1'b0;
      vec_we_q     <= 1'b0;
      txack_q      <= 1'b0;
    end else begin
      exec_start_q <= exec_start_d;
      illegal_q    <= illegal_d;
      vec_we_q     <= vec_we_d;
      txack_q      <= txack_d;
    end
  end

  // Handshake flags, payload registers, write pointer and readback pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed       <= 1'b1;
      fresh       <= 1'b0;
      op_q        <= '0;
      template_q  <= '0;
      force_q     <= '0;
      cycle_q     <= '0;
      delay1_q    <= '0;
      delay2_q    <= '0;
      width_q     <= '0;
      length_q    <= '0;
      vec_wdata_q <= '0;
      vec_count_q <= '0;
      rd_addr_q   <= '0;
      txdata_q    <= '0;
    end else begin
      // re-arm only after READY drops, so a held READY is consumed once
      if (!bus.rxdata_ready) armed <= 1'b1;
      else if (accept)       armed <= 1'b0;

      if (state == ST_IDLE && accept && has_payload(rx_op)) op_q <= rx_op;

      if (state == ST_PAYLOAD && accept) begin
        case (op_q)
          OP_TEMPLATE: template_q <= bus.rxdata;
          OP_FORCE:    force_q    <= bus.rxdata;
          OP_CYCLE:    cycle_q    <= bus.rxdata;
          OP_TIMING: begin
            delay1_q <= bus.rxdata[DELAY1_LSB +: 8];
            delay2_q <= bus.rxdata[DELAY2_LSB +: 8];
            width_q  <= bus.rxdata[WIDTH_LSB  +: 8];
            length_q <= bus.rxdata[LENGTH_LSB +: 8];
          end
          default: ;
        endcase
      end

      // Write lands at the current count; the count steps while the
      // strobe is out so vec_addr still names the slot being written.
      if (vec_we_d) begin
        vec_wdata_q <= bus.rxdata;
        if (fresh) begin
          vec_count_q <= '0;
          fresh       <= 1'b0;
        end
      end else if (vec_we_q) begin
        vec_count_q <= vec_count_q + 1'b1;
      end

      if (state == ST_EXEC && bus.exec_done) begin
        rd_addr_q <= '0;
        fresh     <= 1'b1;
      end

      if (state == ST_TX_CAP) txdata_q <= bus.rd_data;

      if (state == ST_TX_WAIT && bus.txsent) rd_addr_q <= rd_addr_q + 1'b1;
    end
  end

  assign bus.rxdata_retrieved = accept;
  assign bus.template_vec     = template_q;
  assign bus.force_fmt        = force_q;
  assign bus.cycle            = cycle_q;
  assign bus.delay1           = delay1_q;
  assign bus.delay2           = delay2_q;
  assign bus.width            = width_q;
  assign bus.length           = length_q;
  assign bus.vec_we           = vec_we_q;
  assign bus.vec_addr         = vec_count_q[DEPTH_BITS-1:0];
  assign bus.vec_wdata        = vec_wdata_q;
  assign bus.vec_count        = vec_count_q;
  assign bus.exec_start       = exec_start_q;
  assign bus.rd_en            = rd_en;
  assign bus.rd_addr          = rd_addr_q;
  assign bus.txdata           = txdata_q;
  assign bus.txcapture        = txcapture;
  assign bus.txtransmit       = txtransmit;
  assign bus.txack            = txack_q;
  assign bus.illegal          = illegal_q;
  assign bus.busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder with a 4-entry vector SRAM.
module tb_uart_cmd_decoder;
  import uart_cmd_decoder_pkg::*;

  localparam int DB = 2;

  localparam int EV_WE   = 0;
  localparam int EV_EXEC = 1;
  localparam int EV_ILL  = 2;
  localparam int EV_RD   = 3;
  localparam int EV_CAP  = 4;
  localparam int EV_TX   = 5;
  localparam int EV_ACK  = 6;

  typedef struct {
    int           kind;
    int           addr;
    logic [127:0] data;
  } ev_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   retrieved_cnt = 0;
  ev_t  exp_q[$];

  logic [127:0] mem [4];
  logic [127:0] vec [8];
  logic [127:0] p0;

  uart_cmd_decoder_if #(.DEPTH_BITS(DB)) bus();

  uart_cmd_decoder #(.DEPTH_BITS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: write port from the decoder, registered read port
  always @(posedge clk) if (bus.vec_we) mem[bus.vec_addr] <= bus.vec_wdata;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         bus.rd_data <= '0;
    else if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic push(input int k, input int a, input logic [127:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input int a, input logic [127:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%h, none expected", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        errors++;
        $display("FAIL event: got kind=%0d addr=%0d data=%h, want kind=%0d addr=%0d data=%h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every strobe the DUT raises is matched against the queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rxdata_retrieved) retrieved_cnt++;
      if (bus.vec_we)     check_ev(EV_WE, int'(bus.vec_addr), bus.vec_wdata);
      if (bus.exec_start) check_ev(EV_EXEC, 0, '0);
      if (bus.illegal)    check_ev(EV_ILL, 0, '0);
      if (bus.rd_en)      check_ev(EV_RD, int'(bus.rd_addr), '0);
      if (bus.txcapture)  check_ev(EV_CAP, 0, '0);
      if (bus.txtransmit) check_ev(EV_TX, 0, bus.txdata);
      if (bus.txack)      check_ev(EV_ACK, 0, '0);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no response, want one", name);
  endtask

  // Present one packet until retrieved, then drop READY for one edge
  task automatic send_pkt(input logic [127:0] d);
    bit got = 0;
    bus.rxdata_ready = 1'b1;
    bus.rxdata       = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rxdata_retrieved) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) timeout("retrieve");
    tick();
    bus.rxdata_ready = 1'b0;
    tick();
  endtask

  task automatic cmd(input logic [7:0] op, input logic [127:0] payload);
    send_pkt({120'd0, op});
    send_pkt(payload);
  endtask

  // Wait for txtransmit, answer with txsent, wait for txack
  task automatic tx_handshake();
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.txtransmit) begin got = 1; break; end
    end
    if (!got) timeout("txtransmit");
    tick(); tick();
    bus.txsent = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.txack) begin got = 1; break; end
    end
    if (!got) timeout("txack");
    tick();
    bus.txsent = 1'b0;
    tick();
  endtask

  initial begin
    int c0;
    bit got;
    for (int i = 0; i < 8; i++) vec[i] = {4{32'h5A00_0000 | i}};
    p0 = 128'h0123456789ABCDEF0123456789ABCDEF;

    rst_n = 1'b0;
    bus.rxdata_ready = 1'b0;
    bus.rxdata       = '0;
    bus.exec_done    = 1'b0;
    bus.txsent       = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("reset_busy",      bus.busy,         0);
    chk("reset_template",  bus.template_vec, 0);
    chk("reset_vec_count", bus.vec_count,    0);
    chk("reset_rd_addr",   bus.rd_addr,      0);
    chk("reset_txdata",    bus.txdata,       0);

    // register loads
    cmd(OP_TEMPLATE, p0);
    chk("template",        bus.template_vec, p0);
    chk("force_untouched", bus.force_fmt,    0);
    chk("cycle_untouched", bus.cycle,        0);
    cmd(OP_CYCLE, ~p0);
    chk("cycle",           bus.cycle,        ~p0);
    cmd(OP_TIMING, 128'h0A141E64);
    chk("delay1", bus.delay1, 8'd10);
    chk("delay2", bus.delay2, 8'd20);
    chk("width",  bus.width,  8'd30);
    chk("length", bus.length, 8'd100);

    // rejected commands
    push(EV_ILL, 0, '0);
    send_pkt(128'd5);
    chk("exec_empty_busy", bus.busy, 0);
    push(EV_ILL, 0, '0);
    send_pkt(128'd9);

    // three input vectors
    for (int i = 0; i < 3; i++) begin
      push(EV_WE, i, vec[i]);
      cmd(OP_INPUT, vec[i]);
    end
    chk("vec_count_3", bus.vec_count, 3);

    // execute; a packet offered meanwhile waits until done
    push(EV_EXEC, 0, '0);
    send_pkt(128'd5);
    chk("exec_busy", bus.busy, 1);
    c0 = retrieved_cnt;
    bus.rxdata_ready = 1'b1;
    bus.rxdata       = 128'd9;
    repeat (3) tick();
    chk("exec_backpressure", retrieved_cnt, c0);
    chk("exec_still_busy",   bus.busy, 1);
    push(EV_ILL, 0, '0);
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    send_pkt(128'd9);
    chk("exec_done_idle", bus.busy, 0);

    // two readbacks
    for (int i = 0; i < 2; i++) begin
      push(EV_RD, i, '0);
      push(EV_CAP, 0, '0);
      push(EV_TX, 0, vec[i]);
      push(EV_ACK, 0, '0);
      send_pkt({120'd0, OP_READ});
      tx_handshake();
    end
    chk("rd_addr_2", bus.rd_addr, 2);

    // vector list restarts after execute, then fills and rejects
    for (int i = 3; i < 7; i++) begin
      push(EV_WE, i - 3, vec[i]);
      cmd(OP_INPUT, vec[i]);
      if (i == 3) chk("fresh_count_1", bus.vec_count, 1);
    end
    chk("vec_count_full", bus.vec_count, 4);
    push(EV_ILL, 0, '0);
    cmd(OP_INPUT, vec[7]);
    chk("vec_count_held", bus.vec_count, 4);

    // held READY is consumed only once
    c0 = retrieved_cnt;
    push(EV_ILL, 0, '0);
    bus.rxdata_ready = 1'b1;
    bus.rxdata       = 128'd9;
    repeat (8) tick();
    chk("held_ready_once", retrieved_cnt, c0 + 1);
    bus.rxdata_ready = 1'b0;
    tick();

    // reset while waiting for txsent: no txack, everything cleared
    push(EV_RD, 2, '0);
    push(EV_CAP, 0, '0);
    push(EV_TX, 0, vec[5]);
    send_pkt({120'd0, OP_READ});
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.txtransmit) begin got = 1; break; end
    end
    if (!got) timeout("txtransmit_rst");
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rst_busy",      bus.busy,         0);
    chk("rst_template",  bus.template_vec, 0);
    chk("rst_vec_count", bus.vec_count,    0);
    chk("rst_txdata",    bus.txdata,       0);
    chk("rst_rd_addr",   bus.rd_addr,      0);
    chk("rst_delay1",    bus.delay1,       0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_no_txack", bus.txack, 0);
    chk("queue_empty",  exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
